class2_tree_feeder: RTL and testbench
=====================================

# class2_tree_feeder

Front-end/back-end companion for the combinational `class2_tree*` classifiers: accepts feature vectors as a byte stream with valid/ready handshake, assembles the 51-bit feature word that drives a classifier's `i` input, samples the classifier's 1-bit `o` result, and returns it as a handshaked result beat. It is the writer/reader pair around the classifier, turning a pure combinational tree into a streaming, back-pressured inference unit with sample counting and framing-error detection.

## Interface
- `FEAT_W`, 51: feature vector width; must match classifier `i` width.
- `BYTE_W`, 8: stream beat width.
- `NBEATS`, ceil(FEAT_W/BYTE_W) = 7: beats per vector (derived, not overridden).
- `CNT_W`, 16: result counter width.

- `clk`  in  1  single clock, all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  feature beat valid.
- `s_ready`  out  1  feature beat accepted when `s_valid & s_ready`.
- `s_data`  in  BYTE_W  feature byte.
- `s_last`  in  1  marks final beat of a vector.
- `feat_o`  out  FEAT_W  registered feature word to classifier `i`.
- `cls_i`  in  1  classifier `o`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumer ready.
- `m_class`  out  1  registered classification.
- `m_count`  out  CNT_W  number of results delivered.
- `err_o`  out  1  sticky framing error.

## Operation
- Packing: beat k (0..6) writes `feat_o[8k+7:8k]`, LSB-first; beat 6 writes only bits 50:48 from `s_data[2:0]`, `s_data[7:3]` ignored.
- States: LOAD, DRAIN, EVAL, OUT.
- LOAD: `s_ready`=1. Each accepted beat writes its slice and increments beat counter `bc`.
  - Accepted beat with `s_last`=1 and `bc`=6 → EVAL, `bc`←0.
  - Accepted beat with `s_last`=1 and `bc`<6 (short frame) → set `err_o`, `bc`←0, stay LOAD; vector discarded (no result).
  - Accepted beat with `bc`=6 and `s_last`=0 (long frame) → set `err_o`, `bc`←0, → DRAIN.
- DRAIN: `s_ready`=1; beats accepted and dropped, `feat_o` unchanged; accepted beat with `s_last`=1 → LOAD.
- EVAL: `s_ready`=0; `feat_o` stable; `m_class`←`cls_i` at end of cycle; → OUT.
- OUT: `s_ready`=0, `m_valid`=1, `m_class` held stable until `m_valid & m_ready`; on handshake `m_count`++ (wraps 2^CNT_W−1 → 0), → LOAD.
- `err_o` clears only on `rst`.
- Partially written `feat_o` bytes from discarded frames remain until overwritten; no result is ever produced from them.

## Timing
- Reset: state LOAD, `bc`=0, `s_ready`=0 during the reset cycle and 1 from the first cycle after `rst` deasserts; `feat_o`=0, `m_valid`=0, `m_class`=0, `m_count`=0, `err_o`=0.
- `rst` mid-frame or in OUT: abandons frame/result immediately; no handshake is completed that cycle.
- Latency: last beat accepted in cycle T → EVAL in T+1 (classifier sees full `feat_o` from T+1) → `m_valid` high in T+2.
- Throughput: 7 beats + EVAL + ≥1 OUT cycle = 9 cycles/vector minimum; no overlap of load and result.
- `m_ready` held high in OUT: handshake in the first OUT cycle, `s_ready` high the next cycle.
- `m_valid` never drops without handshake; `m_class`/`m_count` registered, no combinational path from `m_ready` or `s_valid` to any output except none (all outputs registered or state-decoded).
- `s_valid` gaps allowed anywhere in a frame; `bc` holds.

## Test plan
- Reset then 7 beats 0x01,0x00,…,0x00,0x07 (s_last on 7th), `cls_i` tied to `feat_o[0]`, `m_ready`=1 → `feat_o`=51'h7_0000_0000_0001, `m_valid` at T+2, `m_class`=1, `m_count`=1.
- Same frame with `m_ready`=0 for 5 cycles → `m_valid`, `m_class` stable 5 cycles, `s_ready`=0 throughout, `m_count` increments once on release.
- Short frame (3 beats, s_last on 3rd) then valid 7-beat frame → `err_o`=1 after beat 3, exactly one result, `m_count`=1.
- Long frame (9 beats, s_last on 9th) → `err_o`=1, DRAIN drops beats 8–9, no result; next valid frame yields one result.
- Preload `m_count`=16'hFFFF via 65535 frames (or forced), one more frame → `m_count`=0.
- Assert `rst` at beat 4 and again during OUT → all outputs return to reset values next cycle, no result emitted, `err_o`=0.

Source files
------------

// File: rtl/class2_tree_feeder_if.sv
// class2_tree_feeder_if: feature byte stream in, classification result out.
interface class2_tree_feeder_if #(
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [BYTE_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic              m_class;
    logic [CNT_W-1:0]  m_count;
    modport master (output s_valid, s_data, s_last, m_ready,
                    input  s_ready, m_valid, m_class, m_count);
    modport slave  (input  s_valid, s_data, s_last, m_ready,
                    output s_ready, m_valid, m_class, m_count);
endinterface

// File: rtl/class2_tree_feeder.sv
// class2_tree_feeder: packs a byte stream into a classifier feature word and returns the result.
module class2_tree_feeder #(
    parameter int FEAT_W = 51,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    class2_tree_feeder_if.slave bus,
    output logic [FEAT_W-1:0]  feat_o,
    input  logic               cls_i,
    output logic               err_o
);
    localparam int NBEATS = (FEAT_W + BYTE_W - 1) / BYTE_W;
    localparam int BC_W   = $clog2(NBEATS);
    typedef enum logic [1:0] {LOAD, DRAIN, EVAL, OUT} state_t;
    state_t            state_q, state_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [FEAT_W-1:0] feat_q, feat_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              class_q, class_d, err_q, err_d;
    logic              accept, last_beat;
    assign bus.s_ready = !rst && (state_q == LOAD || state_q == DRAIN);
    assign bus.m_valid = !rst && state_q == OUT;
    assign bus.m_class = class_q;
    assign bus.m_count = count_q;
    assign feat_o      = feat_q;
    assign err_o       = err_q;
    assign accept      = bus.s_valid && bus.s_ready;
    assign last_beat   = bc_q == BC_W'(NBEATS - 1);
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        feat_d  = feat_q;
        count_d = count_q;
        class_d = class_q;
        err_d   = err_q;
        case (state_q)
            LOAD: if (accept) begin
                // The final beat only carries the bits that fit below FEAT_W.
                for (int k = 0; k < FEAT_W; k++)
                    if (k / BYTE_W == int'(bc_q)) feat_d[k] = bus.s_data[k % BYTE_W];
                bc_d = bc_q + 1'b1;
                if (bus.s_last || last_beat) begin
                    bc_d    = '0;
                    err_d   = err_q || !(bus.s_last && last_beat);
                    state_d = bus.s_last ? (last_beat ? EVAL : LOAD) : DRAIN;
                end
            end
            DRAIN: state_d = (accept && bus.s_last) ? LOAD : DRAIN;
            EVAL: begin
                class_d = cls_i;
                state_d = OUT;
            end
            OUT: if (bus.m_ready) begin
                count_d = count_q + 1'b1;
                state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            bc_q    <= '0;
            feat_q  <= '0;
            count_q <= '0;
            class_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            feat_q  <= feat_d;
            count_q <= count_d;
            class_q <= class_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_class2_tree_feeder.sv
// tb_class2_tree_feeder: directed checks of framing, result handshake and counter behaviour.
module tb_class2_tree_feeder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [50:0] feat;
    logic        cls;
    logic        err;
    int          checks = 0;
    int          errors = 0;
    class2_tree_feeder_if #(.BYTE_W(8), .CNT_W(16)) bus ();
    class2_tree_feeder #(.FEAT_W(51), .BYTE_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .feat_o(feat), .cls_i(cls), .err_o(err)
    );
    assign cls = feat[0];
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0);
        send_beat(b0, 1'b0);
        for (int i = 0; i < 5; i++) send_beat(8'h00, 1'b0);
        send_beat(8'h07, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_result(input string name, input logic c, input logic [15:0] cnt);
        int n = 0;
        while (!bus.m_valid && n < 5) begin
            tick();
            n++;
        end
        checks++;
        if (bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s result timeout m_valid=%b required 1", name, bus.m_valid);
        end
        checks++;
        if (bus.m_class !== c) begin
            errors++;
            $display("FAIL %s m_class=%b required %b", name, bus.m_class, c);
        end
        tick();
        checks++;
        if (bus.m_count !== cnt || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s after handshake m_count=%h m_valid=%b required %h 0", name, bus.m_count, bus.m_valid, cnt);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s extra result m_valid=%b s_ready=%b required 0 1", name, bus.m_valid, bus.s_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || feat !== '0 || bus.m_class !== 1'b0 ||
            bus.m_count !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset s_ready=%b m_valid=%b feat=%h class=%b count=%h err=%b required all 0",
                     bus.s_ready, bus.m_valid, feat, bus.m_class, bus.m_count, err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release s_ready=%b required 1", bus.s_ready);
        end
    endtask

    task automatic test_basic();
        bus.m_ready = 1'b1;
        send_frame(8'h01);
        checks++;
        if (feat !== 51'h7_0000_0000_0001 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_eval feat=%h m_valid=%b s_ready=%b required 70000000000001 0 0", feat, bus.m_valid, bus.s_ready);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_class !== 1'b1 || bus.s_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_out m_valid=%b m_class=%b s_ready=%b required 1 1 0", bus.m_valid, bus.m_class, bus.s_ready);
        end
        tick();
        checks++;
        if (bus.m_count !== 16'd1 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_done m_count=%h m_valid=%b s_ready=%b required 0001 0 1", bus.m_count, bus.m_valid, bus.s_ready);
        end
    endtask

    task automatic test_backpressure();
        bus.m_ready = 1'b0;
        send_frame(8'h01);
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.m_valid !== 1'b1 || bus.m_class !== 1'b1 || bus.s_ready !== 1'b0 || bus.m_count !== 16'd1) begin
                errors++;
                $display("FAIL backpressure cycle %0d m_valid=%b m_class=%b s_ready=%b m_count=%h required 1 1 0 0001",
                         i, bus.m_valid, bus.m_class, bus.s_ready, bus.m_count);
            end
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        checks++;
        if (bus.m_count !== 16'd2 || bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release m_count=%h m_valid=%b required 0002 0", bus.m_count, bus.m_valid);
        end
    endtask

    task automatic test_short_frame();
        do_reset();
        bus.m_ready = 1'b1;
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        send_beat(8'hCC, 1'b1);
        checks++;
        if (err !== 1'b1 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL short_frame err=%b m_valid=%b s_ready=%b required 1 0 1", err, bus.m_valid, bus.s_ready);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_frame_no_result m_valid=%b required 0", bus.m_valid);
        end
        send_frame(8'h02);
        checks++;
        if (feat !== 51'h7_0000_0000_0002) begin
            errors++;
            $display("FAIL short_recover feat=%h required 70000000000002", feat);
        end
        expect_result("short_recover", 1'b0, 16'd1);
    endtask

    task automatic test_long_frame();
        do_reset();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 7; i++) send_beat(8'(i * 8'h11), 1'b0);
        checks++;
        if (err !== 1'b1 || feat !== 51'h7_6655_4433_2211 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL long_frame err=%b feat=%h s_ready=%b required 1 76655443322 11 1", err, feat, bus.s_ready);
        end
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b1);
        checks++;
        if (feat !== 51'h7_6655_4433_2211 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1) begin
            errors++;
            $display("FAIL long_drain feat=%h m_valid=%b s_ready=%b required 76655443322 11 0 1", feat, bus.m_valid, bus.s_ready);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_no_result m_valid=%b required 0", bus.m_valid);
        end
        send_frame(8'h01);
        expect_result("long_recover", 1'b1, 16'd1);
    endtask

    task automatic test_count_wrap();
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        checks++;
        if (bus.m_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload m_count=%h required ffff", bus.m_count);
        end
        send_frame(8'h03);
        expect_result("count_wrap", 1'b1, 16'h0000);
    endtask

    task automatic test_rst_mid();
        send_beat(8'h55, 1'b0);
        send_beat(8'h55, 1'b0);
        send_beat(8'h55, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h66;
        rst = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        checks++;
        if (feat !== '0 || err !== 1'b0 || bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_count !== '0) begin
            errors++;
            $display("FAIL rst_mid_frame feat=%h err=%b s_ready=%b m_valid=%b m_count=%h required 0 0 0 0 0",
                     feat, err, bus.s_ready, bus.m_valid, bus.m_count);
        end
        rst = 1'b0;
        bus.m_ready = 1'b0;
        send_frame(8'h01);
        tick();
        checks++;
        if (bus.m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_out_setup m_valid=%b required 1", bus.m_valid);
        end
        bus.m_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.m_count !== '0 || bus.m_class !== 1'b0 || feat !== '0) begin
            errors++;
            $display("FAIL rst_in_out m_valid=%b m_count=%h m_class=%b feat=%h required 0 0 0 0",
                     bus.m_valid, bus.m_count, bus.m_class, feat);
        end
        tick();
        checks++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1 || bus.m_count !== '0) begin
            errors++;
            $display("FAIL rst_after m_valid=%b s_ready=%b m_count=%h required 0 1 0", bus.m_valid, bus.s_ready, bus.m_count);
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_count_wrap();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
